xor_mix_pipe: RTL and testbench

Parametrised, elastic successor to the single-cycle registered XOR used in the DES datapath. It combines LANES independent WIDTH-bit operand pairs under a selectable operation, including XOR against an internally held key register. Results pass through a DEPTH-stage valid/ready pipeline with per-stage bubble collapsing. It sits between the key-schedule/expansion logic and the S-box stage, and can absorb downstream stalls without dropping data.

---
 rtl/xor_mix_pkg.sv | 28 ++
 rtl/xor_mix_stage.sv | 37 +++
 rtl/xor_mix_pipe.sv | 73 +++++++
 tb/tb_xor_mix_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_mix_pkg.sv
// Shared definitions for the xor_mix pipeline: operation encodings and the per-lane combiner.
package xor_mix_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_XOR  = 2'b01,
    OP_XNOR = 2'b10,
    OP_KEY  = 2'b11
  } op_e;

  // Widest lane the combiner handles; narrower lanes are zero-extended and truncated back.
  localparam int unsigned MaxLaneW = 64;

  typedef logic [MaxLaneW-1:0] lane_t;

  function automatic lane_t mix_lane(op_e op, lane_t x, lane_t y, lane_t key);
    lane_t res;
    res = x;
    unique case (op)
      OP_PASS: res = x;
      OP_XOR:  res = x ^ y;
      OP_XNOR: res = x ^ ~y;
      OP_KEY:  res = x ^ key;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/xor_mix_stage.sv
// One valid/data slot of the elastic pipeline; accepts whenever empty or draining downstream.
module xor_mix_stage
  import xor_mix_pkg::*;
#(
  parameter int unsigned DataW = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [DataW-1:0] i_data,
  input  logic             i_ready,
  output logic             o_ready,
  output logic             o_valid,
  output logic [DataW-1:0] o_data
);

  logic             r_valid;
  logic [DataW-1:0] r_data;
  logic             w_load;

  // An empty slot lets upstream advance even while downstream stalls.
  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

endmodule

// File: rtl/xor_mix_pipe.sv
// Multi-lane XOR/XNOR/key mixer feeding a DEPTH-stage valid/ready pipeline with bubble collapsing.
module xor_mix_pipe
  import xor_mix_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [1:0]             i_op,
  input  logic [LANES*WIDTH-1:0] i_x,
  input  logic [LANES*WIDTH-1:0] i_y,
  input  logic                   i_key_we,
  input  logic [LANES*WIDTH-1:0] i_key_in,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [LANES*WIDTH-1:0] o_dout,
  output logic                   o_busy
);

  localparam int unsigned DataW = LANES * WIDTH;

  logic [DataW-1:0] r_key;
  logic [DataW-1:0] w_mixed;
  logic [DEPTH:0]   w_valid;
  logic             w_ready [DEPTH+1];
  logic [DataW-1:0] w_data  [DEPTH+1];

  // Key load is independent of the handshake; a same-edge OP_KEY transaction sees the old key.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key <= '0;
    end else if (i_key_we) begin
      r_key <= i_key_in;
    end
  end

  // WIDTH must not exceed MaxLaneW.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_mixed[l*WIDTH +: WIDTH] = WIDTH'(mix_lane(op_e'(i_op),
                                                       lane_t'(i_x[l*WIDTH +: WIDTH]),
                                                       lane_t'(i_y[l*WIDTH +: WIDTH]),
                                                       lane_t'(r_key[l*WIDTH +: WIDTH])));
  end

  assign w_valid[0]     = i_in_valid;
  assign w_data[0]      = w_mixed;
  assign w_ready[DEPTH] = i_out_ready;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    xor_mix_stage #(
      .DataW(DataW)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (w_valid[s]),
      .i_data  (w_data[s]),
      .i_ready (w_ready[s+1]),
      .o_ready (w_ready[s]),
      .o_valid (w_valid[s+1]),
      .o_data  (w_data[s+1])
    );
  end

  assign o_in_ready  = w_ready[0];
  assign o_out_valid = w_valid[DEPTH];
  assign o_dout      = w_data[DEPTH];
  assign o_busy      = |w_valid[DEPTH:1];

endmodule

// File: tb/tb_xor_mix_pipe.sv
// Directed-vector and scoreboard bench for xor_mix_pipe (2-lane/2-deep and 1-lane/3-deep builds).
module tb_xor_mix_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=32, LANES=2, DEPTH=2
  logic        a_in_valid, a_in_ready, a_key_we, a_out_valid, a_out_ready, a_busy;
  logic [1:0]  a_op;
  logic [63:0] a_x, a_y, a_key_in, a_dout;

  // Instance B: WIDTH=32, LANES=1, DEPTH=3
  logic        b_in_valid, b_in_ready, b_key_we, b_out_valid, b_out_ready, b_busy;
  logic [1:0]  b_op;
  logic [31:0] b_x, b_y, b_key_in, b_dout;

  xor_mix_pipe #(.WIDTH(32), .LANES(2), .DEPTH(2)) u_dut_a (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (a_in_valid),
    .o_in_ready  (a_in_ready),
    .i_op        (a_op),
    .i_x         (a_x),
    .i_y         (a_y),
    .i_key_we    (a_key_we),
    .i_key_in    (a_key_in),
    .o_out_valid (a_out_valid),
    .i_out_ready (a_out_ready),
    .o_dout      (a_dout),
    .o_busy      (a_busy)
  );

  xor_mix_pipe #(.WIDTH(32), .LANES(1), .DEPTH(3)) u_dut_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (b_in_valid),
    .o_in_ready  (b_in_ready),
    .i_op        (b_op),
    .i_x         (b_x),
    .i_y         (b_y),
    .i_key_we    (b_key_we),
    .i_key_in    (b_key_in),
    .o_out_valid (b_out_valid),
    .i_out_ready (b_out_ready),
    .o_dout      (b_dout),
    .o_busy      (b_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] x, logic [31:0] y,
                                        logic [31:0] k);
    case (op)
      2'b00:   return x;
      2'b01:   return x ^ y;
      2'b10:   return x ^ ~y;
      default: return x ^ k;
    endcase
  endfunction

  // Scoreboard for instance B
  logic [31:0] q[$];
  logic [31:0] m_key = '0;
  int          n_recv = 0;

  task automatic b_cycle(output bit acc);
    #1;
    check("busy_vs_model", 64'(b_busy), 64'(q.size() != 0));
    if (b_out_valid && b_out_ready) begin
      if (q.size() == 0) check("dout_unexpected", 64'(b_out_valid), 64'd0);
      else check("dout_order", 64'(b_dout), 64'(q.pop_front()));
      n_recv++;
    end
    acc = b_in_valid && b_in_ready;
    if (acc) q.push_back(model(b_op, b_x, b_y, m_key));
    if (b_key_we) m_key = b_key_in;
    step();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] exp;
  } vec_t;

  localparam int NVec = 7;
  vec_t vecs[NVec];

  initial begin
    bit acc;
    int sent, got, cnt, n_acc;

    a_in_valid = 0; a_op = 0; a_x = 0; a_y = 0; a_key_we = 0; a_key_in = 0; a_out_ready = 0;
    b_in_valid = 0; b_op = 0; b_x = 0; b_y = 0; b_key_we = 0; b_key_in = 0; b_out_ready = 0;

    vecs[0] = '{2'b00, 64'h12345678_FFFFFFFF, 64'h0000FFFF_00000000, 64'h12345678_FFFFFFFF};
    vecs[1] = '{2'b01, 64'h12345678_FFFFFFFF, 64'h0000FFFF_00000000, 64'h1234A987_FFFFFFFF};
    vecs[2] = '{2'b10, 64'h12345678_FFFFFFFF, 64'h0000FFFF_00000000, 64'hEDCB5678_00000000};
    vecs[3] = '{2'b11, 64'hDEADBEEF_01234567, 64'hFFFFFFFF_FFFFFFFF, 64'hDEADBEEF_01234567};
    vecs[4] = '{2'b01, 64'hA5A5A5A5_0F0F0F0F, 64'h5A5A5A5A_F0F0F0F0, 64'hFFFFFFFF_FFFFFFFF};
    vecs[5] = '{2'b00, 64'h00000000_80000001, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_80000001};
    vecs[6] = '{2'b10, 64'h00000000_00000000, 64'h00000000_00000000, 64'hFFFFFFFF_FFFFFFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_dout", a_dout, 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    rst_n = 1'b1;

    // Latency: captured at edge 1, visible after edge 2
    a_out_ready = 1; a_in_valid = 1; a_op = 2'b01;
    a_x = 64'h00000000_F0F0F0F0; a_y = 64'h00000000_0FF00FF0;
    step();
    a_in_valid = 0;
    check("lat_e1_valid", 64'(a_out_valid), 64'd0);
    check("lat_e1_busy", 64'(a_busy), 64'd1);
    step();
    check("lat_e2_valid", 64'(a_out_valid), 64'd1);
    check("lat_e2_dout", a_dout, 64'h00000000_FF00FF00);

    // Mid-flight reset with a stalled result at the output
    a_out_ready = 0; a_in_valid = 1; a_op = 2'b00; a_x = 64'h13579BDF_2468ACE0;
    step();
    a_in_valid = 0;
    step();
    check("mid_valid_before", 64'(a_out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_dout", a_dout, 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    #2 rst_n = 1'b1;
    step();

    // Table-driven op vectors, streamed back to back
    a_out_ready = 1;
    got = 0;
    for (int c = 0; c < NVec + 4; c++) begin
      if (c < NVec) begin
        a_in_valid = 1; a_op = vecs[c].op; a_x = vecs[c].x; a_y = vecs[c].y;
      end else begin
        a_in_valid = 0;
      end
      if (a_out_valid) begin
        if (got < NVec) check($sformatf("vec%0d", got), a_dout, vecs[got].exp);
        got++;
      end
      step();
    end
    check("vec_count", 64'(got), 64'(NVec));

    // Key write on the same edge as an OP_KEY transaction uses the old key
    a_key_we = 1; a_key_in = 64'hAAAAAAAA_AAAAAAAA;
    a_in_valid = 1; a_op = 2'b11; a_x = 64'd0;
    step();
    a_key_we = 0;
    step();
    a_in_valid = 0;
    check("key_old_valid", 64'(a_out_valid), 64'd1);
    check("key_old", a_dout, 64'd0);
    step();
    check("key_new_valid", 64'(a_out_valid), 64'd1);
    check("key_new", a_dout, 64'hAAAAAAAA_AAAAAAAA);

    // Backpressure on the 3-deep build
    b_op = 2'b00; b_out_ready = 0; b_in_valid = 1; sent = 0;
    for (int c = 0; c < 6; c++) begin
      b_x = 32'(sent);
      b_cycle(acc);
      if (acc) sent++;
    end
    check("bp_accepts", 64'(sent), 64'd3);
    check("bp_in_ready", 64'(b_in_ready), 64'd0);
    check("bp_out_valid", 64'(b_out_valid), 64'd1);
    check("bp_dout_hold", 64'(b_dout), 64'd0);
    b_out_ready = 1;
    for (int c = 0; c < 40 && (sent < 10 || q.size() != 0); c++) begin
      b_in_valid = (sent < 10);
      b_x = 32'(sent);
      b_cycle(acc);
      if (acc) sent++;
    end
    check("bp_recv", 64'(n_recv), 64'd10);
    check("bp_drained", 64'(q.size()), 64'd0);

    // Bubble collapse: one in flight, stall output, two more still fit
    b_in_valid = 1; b_x = 32'h55; b_out_ready = 0;
    b_cycle(acc);
    check("bub_first", 64'(acc), 64'd1);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      b_x = 32'h60 + 32'(c);
      b_cycle(acc);
      if (acc) cnt++;
    end
    check("bub_accepts", 64'(cnt), 64'd2);
    b_in_valid = 0; b_out_ready = 1;
    for (int c = 0; c < 10 && q.size() != 0; c++) b_cycle(acc);
    check("bub_drained", 64'(q.size()), 64'd0);

    // Random handshakes against the scoreboard
    n_acc = 0;
    for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_op        = 2'($urandom_range(0, 3));
      b_x         = $urandom;
      b_y         = $urandom;
      b_key_we    = ($urandom_range(0, 15) == 0);
      b_key_in    = $urandom;
      b_cycle(acc);
      if (acc) n_acc++;
    end
    check("rand_accepts", 64'(n_acc), 64'd10000);
    b_in_valid = 0; b_key_we = 0; b_out_ready = 1;
    for (int c = 0; c < 20 && q.size() != 0; c++) b_cycle(acc);
    check("rand_drained", 64'(q.size()), 64'd0);
    check("rand_busy_idle", 64'(b_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
